shift_cmd_issuer: RTL and testbench

Command-issue stage directly upstream of the combinational 8-bit barrel shifter.
- Buffers shift commands (data, amount, mode) in a small FIFO and presents the head entry on the shifter's input pins.
- Captures the shifter's combinational result into a registered output slot with a valid/ready handshake.
- Decouples bursty command producers from result consumers and gives the shifter a registered, back-pressured wrapper.

---
 rtl/shift_cmd_issuer.sv | 122 ++++++++++++
 tb/tb_shift_cmd_issuer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_cmd_issuer.sv
// Command-issue stage for the 8-bit barrel shifter: a small command FIFO
// drives the shifter pins from its head entry, and the result is registered into a valid/ready slot.
module shift_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_data,
  input  logic [2:0]       cmd_amt,
  input  logic [2:0]       cmd_mode,
  output logic [7:0]       sh_data_in,
  output logic [2:0]       sh_shift_amt,
  output logic [2:0]       sh_mode_sel,
  input  logic [7:0]       sh_data_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [2:0]       res_mode,
  output logic             res_illegal,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [2:0] LAST_LEGAL_MODE = 3'b100;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_t;

  slot_t slot_q, slot_d;

  logic [7:0] data_mem [DEPTH];
  logic [2:0] amt_mem  [DEPTH];
  logic [2:0] mode_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic full, empty, push, pop;

  // Ready comes only from the registered occupancy, so a pop at full never
  // lets a push through in the same cycle.
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign res_valid = (slot_q == SLOT_FULL);
  assign pop       = !empty && (!res_valid || res_ready);

  always_comb begin
    sh_data_in   = '0;
    sh_shift_amt = '0;
    sh_mode_sel  = '0;
    if (!empty) begin
      sh_data_in   = data_mem[rd_ptr];
      sh_shift_amt = amt_mem[rd_ptr];
      sh_mode_sel  = mode_mem[rd_ptr];
    end
  end

  always_comb begin
    slot_d = slot_q;
    if (pop) begin
      slot_d = SLOT_FULL;
    end else if (res_ready) begin
      slot_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= SLOT_EMPTY;
    end else begin
      slot_q <= slot_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= cmd_data;
      amt_mem[wr_ptr]  <= cmd_amt;
      mode_mem[wr_ptr] <= cmd_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // res_data holds its last value when the slot drains without a refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data    <= '0;
      res_mode    <= '0;
      res_illegal <= 1'b0;
    end else if (pop) begin
      res_data    <= sh_data_out;
      res_mode    <= sh_mode_sel;
      res_illegal <= (sh_mode_sel > LAST_LEGAL_MODE);
    end
  end

endmodule

// File: tb/tb_shift_cmd_issuer.sv
// Bench for shift_cmd_issuer: provides the barrel shifter, drives directed and
// random traffic, and compares every output each cycle against a queue-based model.
module tb_shift_cmd_issuer;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_data;
  logic [2:0]       cmd_amt;
  logic [2:0]       cmd_mode;
  logic [7:0]       sh_data_in;
  logic [2:0]       sh_shift_amt;
  logic [2:0]       sh_mode_sel;
  logic [7:0]       sh_data_out;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;
  logic [2:0]       res_mode;
  logic             res_illegal;
  logic [CNT_W-1:0] count;

  shift_cmd_issuer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_amt(cmd_amt), .cmd_mode(cmd_mode),
    .sh_data_in(sh_data_in), .sh_shift_amt(sh_shift_amt), .sh_mode_sel(sh_mode_sel),
    .sh_data_out(sh_data_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_mode(res_mode), .res_illegal(res_illegal),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] shifter(input logic [7:0] d, input logic [2:0] a,
                                         input logic [2:0] m);
    logic [15:0] dd;
    dd = {d, d};
    case (m)
      3'b000:  return 8'((16'(d) << a) & 16'h00FF);
      3'b001:  return d >> a;
      3'b010:  return 8'($signed(d) >>> a);
      3'b011:  return 8'(dd >> a);
      3'b100:  return 8'((dd << a) >> 8);
      default: return d;
    endcase
  endfunction

  assign sh_data_out = shifter(sh_data_in, sh_shift_amt, sh_mode_sel);

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] amt;
    logic [2:0] mode;
  } cmd_t;

  cmd_t       mq[$];
  bit         mv;
  logic [7:0] md;
  logic [2:0] mm;
  bit         mi;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    cmd_t h;
    h = (mq.size() > 0) ? mq[0] : '0;
    check("count",       32'(count),        32'(mq.size()));
    check("cmd_ready",   32'(cmd_ready),    32'(mq.size() < DEPTH));
    check("res_valid",   32'(res_valid),    32'(mv));
    check("res_data",    32'(res_data),     32'(md));
    check("res_mode",    32'(res_mode),     32'(mm));
    check("res_illegal", 32'(res_illegal),  32'(mi));
    check("sh_data_in",  32'(sh_data_in),   32'(h.data));
    check("sh_amt",      32'(sh_shift_amt), 32'(h.amt));
    check("sh_mode",     32'(sh_mode_sel),  32'(h.mode));
  endtask

  // One clock: apply inputs, advance the model at the edge, compare at the falling edge.
  task automatic step(input bit v, input logic [7:0] d, input logic [2:0] a,
                      input logic [2:0] m, input bit rr, input bit r, output bit accepted);
    bit do_pop, do_push;
    cmd_t c;
    cmd_valid = v; cmd_data = d; cmd_amt = a; cmd_mode = m;
    res_ready = rr; rst = r;
    @(posedge clk);
    do_pop   = !r && (mq.size() > 0) && (!mv || rr);
    do_push  = !r && v && (mq.size() < DEPTH);
    accepted = do_push;
    if (r) begin
      mq.delete();
      mv = 0; md = '0; mm = '0; mi = 0;
    end else begin
      if (do_pop) begin
        c = mq.pop_front();
        md = shifter(c.data, c.amt, c.mode);
        mm = c.mode;
        mi = (c.mode >= 3'd5);
        mv = 1;
      end else if (mv && rr) begin
        mv = 0;
      end
      if (do_push) mq.push_back('{data: d, amt: a, mode: m});
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input bit rr);
    bit acc;
    step(0, '0, '0, '0, rr, 0, acc);
  endtask

  task automatic one_cmd(input string tag, input logic [7:0] d, input logic [2:0] a,
                         input logic [2:0] m, input logic [7:0] exp);
    bit acc;
    step(1, d, a, m, 1, 0, acc);
    check({tag, "_acc"}, 32'(acc), 32'd1);
    check({tag, "_early"}, 32'(res_valid), 32'd0);
    idle(1);
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    check({tag, "_data"}, 32'(res_data), 32'(exp));
    check({tag, "_illegal"}, 32'(res_illegal), 32'(m >= 3'd5));
    idle(1);
  endtask

  initial begin
    bit acc;
    int unsigned tries;
    cmd_valid = 0; cmd_data = '0; cmd_amt = '0; cmd_mode = '0; res_ready = 0; rst = 1;
    mv = 0; md = '0; mm = '0; mi = 0;

    step(0, '0, '0, '0, 0, 1, acc);
    step(0, '0, '0, '0, 0, 1, acc);
    check("reset_count", 32'(count), 32'd0);
    check("reset_valid", 32'(res_valid), 32'd0);

    one_cmd("lsl", 8'hB4, 3'd2, 3'b000, 8'hD0);
    one_cmd("lsr", 8'hB4, 3'd2, 3'b001, 8'h2D);
    one_cmd("asr", 8'hB4, 3'd2, 3'b010, 8'hED);
    one_cmd("ror", 8'hB4, 3'd3, 3'b011, 8'h96);
    one_cmd("rol", 8'h81, 3'd1, 3'b100, 8'h03);
    one_cmd("ror0", 8'h5A, 3'd0, 3'b011, 8'h5A);
    one_cmd("illegal", 8'h3C, 3'd5, 3'b111, 8'h3C);
    step(1, 8'h3C, 3'd5, 3'b111, 1, 0, acc);
    idle(0);
    check("illegal_mode", 32'(res_mode), 32'h7);
    idle(1);
    idle(1);

    // Back-pressure: five accepted, sixth waits for space.
    for (int i = 1; i <= 5; i++) begin
      step(1, 8'(i), 3'd1, 3'b000, 0, 0, acc);
      check("bp_acc", 32'(acc), 32'd1);
    end
    step(1, 8'h06, 3'd1, 3'b000, 0, 0, acc);
    check("bp_reject", 32'(acc), 32'd0);
    check("bp_count", 32'(count), 32'd4);
    check("bp_ready", 32'(cmd_ready), 32'd0);
    check("bp_hold", 32'(res_data), 32'h02);
    tries = 0;
    acc = 0;
    while (!acc && tries < 10) begin
      step(1, 8'h06, 3'd1, 3'b000, 1, 0, acc);
      tries++;
    end
    check("bp_sixth_accepted", 32'(acc), 32'd1);
    for (int i = 0; i < 8; i++) idle(1);
    check("bp_last", 32'(res_data), 32'h0C);
    check("bp_drained", 32'(res_valid), 32'd0);

    // Simultaneous push and pop leaves occupancy unchanged.
    for (int i = 0; i < 4; i++) step(1, 8'h10 + 8'(i), 3'(i), 3'b011, 0, 0, acc);
    check("pp_count_before", 32'(count), 32'd3);
    step(1, 8'h20, 3'd2, 3'b001, 1, 0, acc);
    check("pp_count_after", 32'(count), 32'd3);
    for (int i = 0; i < 6; i++) idle(1);

    // Reset mid-burst.
    for (int i = 0; i < 4; i++) step(1, 8'hA0 + 8'(i), 3'd1, 3'b100, 0, 0, acc);
    check("mid_valid", 32'(res_valid), 32'd1);
    step(1, 8'h77, 3'd1, 3'b000, 0, 1, acc);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_sh", 32'({sh_data_in, sh_shift_amt, sh_mode_sel}), 32'd0);
    one_cmd("post_rst", 8'hF0, 3'd4, 3'b010, 8'hFF);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), 3'($urandom), 3'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0, acc);
    end
    for (int i = 0; i < 8; i++) idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
